// File: rtl/ctrl_hazard_pipe.sv
// Pipelined control for the 5-stage MIPS core: D-stage decode, E/M/W control registers,
// and Tuse/Tnew based stall and forwarding-select generation.
module ctrl_hazard_pipe #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned LINK_REG  = 31,
  parameter bit          HAZARD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_d,
  output logic              stall,
  output logic              d_beq,
  output logic              d_j,
  output logic              d_jr,
  output logic              e_alu_src,
  output logic [2:0]        e_aluc,
  output logic              e_zext,
  output logic              e_lui,
  output logic              m_dm_write,
  output logic              w_grf_we,
  output logic [REG_AW-1:0] w_grf_a,
  output logic [1:0]        w_wsel,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic              fwd_m_rt
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSubu  = 6'h23;
  localparam logic [5:0] FnJr    = 6'h08;

  localparam logic [2:0] AlucNone = 3'b000;
  localparam logic [2:0] AlucSub  = 3'b100;
  localparam logic [2:0] AlucAdd  = 3'b010;
  localparam logic [2:0] AlucOr   = 3'b001;

  localparam logic [1:0] WselAlu = 2'd0;
  localparam logic [1:0] WselDm  = 2'd1;
  localparam logic [1:0] WselPc8 = 2'd2;

  // Tuse of 3 means the operand is never read; no producer Tnew can exceed it.
  localparam logic [1:0] TuseNone = 2'd3;

  typedef logic [REG_AW-1:0] addr_t;

  typedef struct packed {
    logic       alu_src;
    logic [2:0] aluc;
    logic       zext;
    logic       lui;
    logic       dm_write;
    addr_t      dst;
    logic [1:0] wsel;
    logic [1:0] tnew;
    addr_t      rs;
    addr_t      rt;
  } e_ctrl_t;

  typedef struct packed {
    logic       dm_write;
    addr_t      dst;
    logic [1:0] wsel;
    logic [1:0] tnew;
    addr_t      rt;
  } m_ctrl_t;

  typedef struct packed {
    addr_t      dst;
    logic [1:0] wsel;
  } w_ctrl_t;

  e_ctrl_t e_q, e_d;
  m_ctrl_t m_q, m_d;
  w_ctrl_t w_q, w_d;

  // ---------------------------------------------------------------------------
  // D-stage decode
  // ---------------------------------------------------------------------------
  logic [5:0] op, fn;
  addr_t      rs_f, rt_f, rd_f;
  logic       unused_shamt;

  assign op           = instr_d[31:26];
  assign fn           = instr_d[5:0];
  assign rs_f         = addr_t'(instr_d[25:21]);
  assign rt_f         = addr_t'(instr_d[20:16]);
  assign rd_f         = addr_t'(instr_d[15:11]);
  assign unused_shamt = ^instr_d[10:6];

  logic       dec_beq, dec_j, dec_jr;
  logic       dec_alu_src, dec_zext, dec_lui, dec_dm_write;
  logic [2:0] dec_aluc;
  addr_t      dec_dst;
  logic [1:0] dec_wsel, dec_tnew;
  logic [1:0] tuse_rs, tuse_rt;

  always_comb begin
    dec_beq      = 1'b0;
    dec_j        = 1'b0;
    dec_jr       = 1'b0;
    dec_alu_src  = 1'b0;
    dec_zext     = 1'b0;
    dec_lui      = 1'b0;
    dec_dm_write = 1'b0;
    dec_aluc     = AlucNone;
    dec_dst      = '0;
    dec_wsel     = WselAlu;
    dec_tnew     = 2'd0;
    tuse_rs      = TuseNone;
    tuse_rt      = TuseNone;
    case (op)
      OpRtype: begin
        case (fn)
          FnAddu: begin
            dec_aluc = AlucAdd;
            dec_dst  = rd_f;
            dec_tnew = 2'd1;
            tuse_rs  = 2'd1;
            tuse_rt  = 2'd1;
          end
          FnSubu: begin
            dec_aluc = AlucSub;
            dec_dst  = rd_f;
            dec_tnew = 2'd1;
            tuse_rs  = 2'd1;
            tuse_rt  = 2'd1;
          end
          FnJr: begin
            dec_jr  = 1'b1;
            tuse_rs = 2'd0;
          end
          default: ;
        endcase
      end
      OpOri: begin
        dec_alu_src = 1'b1;
        dec_aluc    = AlucOr;
        dec_zext    = 1'b1;
        dec_dst     = rt_f;
        dec_tnew    = 2'd1;
        tuse_rs     = 2'd1;
      end
      OpLw: begin
        dec_alu_src = 1'b1;
        dec_aluc    = AlucAdd;
        dec_dst     = rt_f;
        dec_wsel    = WselDm;
        dec_tnew    = 2'd2;
        tuse_rs     = 2'd1;
      end
      OpSw: begin
        dec_alu_src  = 1'b1;
        dec_aluc     = AlucAdd;
        dec_dm_write = 1'b1;
        tuse_rs      = 2'd1;
        tuse_rt      = 2'd2;
      end
      OpBeq: begin
        dec_beq = 1'b1;
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      OpLui: begin
        dec_alu_src = 1'b1;
        dec_aluc    = AlucOr;
        dec_lui     = 1'b1;
        dec_dst     = rt_f;
        dec_tnew    = 2'd1;
        tuse_rs     = 2'd1;
      end
      OpJ: dec_j = 1'b1;
      OpJal: begin
        dec_j    = 1'b1;
        dec_dst  = addr_t'(LINK_REG);
        dec_wsel = WselPc8;
        dec_tnew = 2'd0;
      end
      default: ;
    endcase
  end

  assign d_beq = dec_beq;
  assign d_j   = dec_j;
  assign d_jr  = dec_jr;

  // Unread operands are carried as register 0 so they can never stall or forward.
  addr_t src_rs, src_rt;
  assign src_rs = (tuse_rs == TuseNone) ? '0 : rs_f;
  assign src_rt = (tuse_rt == TuseNone) ? '0 : rt_f;

  // ---------------------------------------------------------------------------
  // Hazard detection and forwarding selects
  // ---------------------------------------------------------------------------
  function automatic logic hit(input addr_t src, input addr_t dst);
    return (src != '0) && (src == dst);
  endfunction

  // Youngest matching producer decides; it forwards only once its result exists.
  function automatic logic [1:0] sel_d(input addr_t src, input addr_t e_dst,
                                       input logic [1:0] e_tnew, input addr_t m_dst,
                                       input logic [1:0] m_tnew);
    logic [1:0] sel;
    sel = 2'd0;
    if (hit(src, e_dst)) begin
      sel = (e_tnew == 2'd0) ? 2'd1 : 2'd0;
    end else if (hit(src, m_dst)) begin
      sel = (m_tnew == 2'd0) ? 2'd2 : 2'd0;
    end
    return sel;
  endfunction

  function automatic logic [1:0] sel_e(input addr_t src, input addr_t m_dst,
                                       input logic [1:0] m_tnew, input addr_t w_dst);
    logic [1:0] sel;
    sel = 2'd0;
    if (hit(src, m_dst)) begin
      sel = (m_tnew == 2'd0) ? 2'd1 : 2'd0;
    end else if (hit(src, w_dst)) begin
      sel = 2'd2;
    end
    return sel;
  endfunction

  logic stall_raw;
  assign stall_raw = (hit(src_rs, e_q.dst) && (tuse_rs < e_q.tnew)) ||
                     (hit(src_rs, m_q.dst) && (tuse_rs < m_q.tnew)) ||
                     (hit(src_rt, e_q.dst) && (tuse_rt < e_q.tnew)) ||
                     (hit(src_rt, m_q.dst) && (tuse_rt < m_q.tnew));

  assign stall    = HAZARD_EN && stall_raw;
  assign fwd_d_rs = HAZARD_EN ? sel_d(src_rs, e_q.dst, e_q.tnew, m_q.dst, m_q.tnew) : 2'd0;
  assign fwd_d_rt = HAZARD_EN ? sel_d(src_rt, e_q.dst, e_q.tnew, m_q.dst, m_q.tnew) : 2'd0;
  assign fwd_e_rs = HAZARD_EN ? sel_e(e_q.rs, m_q.dst, m_q.tnew, w_q.dst) : 2'd0;
  assign fwd_e_rt = HAZARD_EN ? sel_e(e_q.rt, m_q.dst, m_q.tnew, w_q.dst) : 2'd0;
  assign fwd_m_rt = HAZARD_EN && hit(m_q.rt, w_q.dst);

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.alu_src  = dec_alu_src;
      e_d.aluc     = dec_aluc;
      e_d.zext     = dec_zext;
      e_d.lui      = dec_lui;
      e_d.dm_write = dec_dm_write;
      e_d.dst      = dec_dst;
      e_d.wsel     = dec_wsel;
      e_d.tnew     = dec_tnew;
      e_d.rs       = src_rs;
      e_d.rt       = src_rt;
    end

    m_d          = '0;
    m_d.dm_write = e_q.dm_write;
    m_d.dst      = e_q.dst;
    m_d.wsel     = e_q.wsel;
    m_d.tnew     = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
    m_d.rt       = e_q.rt;

    w_d      = '0;
    w_d.dst  = m_q.dst;
    w_d.wsel = m_q.wsel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign e_alu_src  = e_q.alu_src;
  assign e_aluc     = e_q.aluc;
  assign e_zext     = e_q.zext;
  assign e_lui      = e_q.lui;
  assign m_dm_write = m_q.dm_write;
  assign w_grf_we   = (w_q.dst != '0);
  assign w_grf_a    = w_q.dst;
  assign w_wsel     = w_q.wsel;

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// Self-checking bench for ctrl_hazard_pipe: directed hazard scenarios plus random instruction
// streams compared against an instruction-level pipeline model.
module tb_ctrl_hazard_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d;
  logic        stall, d_beq, d_j, d_jr, e_alu_src, e_zext, e_lui, m_dm_write, w_grf_we;
  logic [2:0]  e_aluc;
  logic [4:0]  w_grf_a;
  logic [1:0]  w_wsel, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic        fwd_m_rt;

  logic        nh_stall, nh_fwd_m_rt;
  logic [2:0]  nh_dctl;
  logic [1:0]  nh_fwd_d_rs, nh_fwd_d_rt, nh_fwd_e_rs, nh_fwd_e_rt;
  logic [14:0] nh_unused;

  always #5 clk = ~clk;

  ctrl_hazard_pipe u_dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .stall(stall),
    .d_beq(d_beq), .d_j(d_j), .d_jr(d_jr),
    .e_alu_src(e_alu_src), .e_aluc(e_aluc), .e_zext(e_zext), .e_lui(e_lui),
    .m_dm_write(m_dm_write), .w_grf_we(w_grf_we), .w_grf_a(w_grf_a), .w_wsel(w_wsel),
    .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
    .fwd_m_rt(fwd_m_rt)
  );

  ctrl_hazard_pipe #(.HAZARD_EN(1'b0)) u_dut_nohaz (
    .clk(clk), .reset(reset), .instr_d(instr_d), .stall(nh_stall),
    .d_beq(nh_dctl[2]), .d_j(nh_dctl[1]), .d_jr(nh_dctl[0]),
    .e_alu_src(nh_unused[0]), .e_aluc(nh_unused[3:1]), .e_zext(nh_unused[4]),
    .e_lui(nh_unused[5]), .m_dm_write(nh_unused[6]), .w_grf_we(nh_unused[7]),
    .w_grf_a(nh_unused[12:8]), .w_wsel(nh_unused[14:13]),
    .fwd_d_rs(nh_fwd_d_rs), .fwd_d_rt(nh_fwd_d_rt), .fwd_e_rs(nh_fwd_e_rs),
    .fwd_e_rt(nh_fwd_e_rt), .fwd_m_rt(nh_fwd_m_rt)
  );

  wire [27:0] all_outs = {stall, d_beq, d_j, d_jr, e_alu_src, e_aluc, e_zext, e_lui,
                          m_dm_write, w_grf_we, w_grf_a, w_wsel,
                          fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt};

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // Reference model: instruction words held per stage (index 0=E, 1=M, 2=W)
  // ---------------------------------------------------------------------------
  localparam int KNop = 0, KAddu = 1, KSubu = 2, KOri = 3, KLw = 4, KSw = 5;
  localparam int KBeq = 6, KLui = 7, KJ = 8, KJal = 9, KJr = 10;

  logic [31:0] st [3];
  logic        exp_stall;
  logic [2:0]  exp_dctl;
  logic [5:0]  exp_ectl;
  logic [8:0]  exp_mw;
  logic [8:0]  exp_fwd;

  function automatic int kind_of(input logic [31:0] ins);
    int k;
    k = KNop;
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] == 6'h21) k = KAddu;
        else if (ins[5:0] == 6'h23) k = KSubu;
        else if (ins[5:0] == 6'h08) k = KJr;
      end
      6'h0d: k = KOri;
      6'h23: k = KLw;
      6'h2b: k = KSw;
      6'h04: k = KBeq;
      6'h0f: k = KLui;
      6'h02: k = KJ;
      6'h03: k = KJal;
      default: k = KNop;
    endcase
    return k;
  endfunction

  function automatic logic [4:0] dst_of(input logic [31:0] ins);
    int k;
    k = kind_of(ins);
    if (k == KAddu || k == KSubu) return ins[15:11];
    if (k == KOri || k == KLw || k == KLui) return ins[20:16];
    if (k == KJal) return 5'd31;
    return 5'd0;
  endfunction

  // Cycles after entering E before the result exists.
  function automatic int latency_of(input logic [31:0] ins);
    int k;
    k = kind_of(ins);
    if (k == KLw) return 2;
    if (k == KAddu || k == KSubu || k == KOri || k == KLui) return 1;
    return 0;
  endfunction

  function automatic int ready_in(input logic [31:0] ins, input int age);
    int l;
    l = latency_of(ins);
    return (l > age) ? l - age : 0;
  endfunction

  function automatic int need_rs(input logic [31:0] ins);
    int k;
    k = kind_of(ins);
    if (k == KBeq || k == KJr) return 0;
    if (k == KAddu || k == KSubu || k == KOri || k == KLw || k == KLui || k == KSw) return 1;
    return 3;
  endfunction

  function automatic int need_rt(input logic [31:0] ins);
    int k;
    k = kind_of(ins);
    if (k == KBeq) return 0;
    if (k == KAddu || k == KSubu) return 1;
    if (k == KSw) return 2;
    return 3;
  endfunction

  function automatic logic [4:0] src_rs(input logic [31:0] ins);
    return (need_rs(ins) < 3) ? ins[25:21] : 5'd0;
  endfunction

  function automatic logic [4:0] src_rt(input logic [31:0] ins);
    return (need_rt(ins) < 3) ? ins[20:16] : 5'd0;
  endfunction

  function automatic logic [1:0] model_fwd_d(input logic [4:0] s);
    if (s == 5'd0) return 2'd0;
    if (dst_of(st[0]) == s) return (ready_in(st[0], 0) == 0) ? 2'd1 : 2'd0;
    if (dst_of(st[1]) == s) return (ready_in(st[1], 1) == 0) ? 2'd2 : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic [1:0] model_fwd_e(input logic [4:0] s);
    if (s == 5'd0) return 2'd0;
    if (dst_of(st[1]) == s) return (ready_in(st[1], 1) == 0) ? 2'd1 : 2'd0;
    if (dst_of(st[2]) == s) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_eval();
    int kd, ke, kw;
    logic [4:0] s;
    int nd;
    kd = kind_of(instr_d);
    exp_stall = 1'b0;
    for (int opnd = 0; opnd < 2; opnd++) begin
      s  = (opnd == 0) ? src_rs(instr_d) : src_rt(instr_d);
      nd = (opnd == 0) ? need_rs(instr_d) : need_rt(instr_d);
      for (int a = 0; a < 2; a++) begin
        if (s != 5'd0 && dst_of(st[a]) == s && nd < ready_in(st[a], a)) exp_stall = 1'b1;
      end
    end
    exp_dctl = {kd == KBeq, kd == KJ || kd == KJal, kd == KJr};
    ke = kind_of(st[0]);
    exp_ectl[5]   = (ke == KOri || ke == KLw || ke == KSw || ke == KLui);
    exp_ectl[4:2] = (ke == KAddu || ke == KLw || ke == KSw) ? 3'b010 :
                    (ke == KSubu) ? 3'b100 :
                    (ke == KOri || ke == KLui) ? 3'b001 : 3'b000;
    exp_ectl[1]   = (ke == KOri);
    exp_ectl[0]   = (ke == KLui);
    kw = kind_of(st[2]);
    exp_mw = {kind_of(st[1]) == KSw, dst_of(st[2]) != 5'd0, dst_of(st[2]),
              (kw == KLw) ? 2'd1 : (kw == KJal) ? 2'd2 : 2'd0};
    exp_fwd = {model_fwd_d(src_rs(instr_d)), model_fwd_d(src_rt(instr_d)),
               model_fwd_e(src_rs(st[0])), model_fwd_e(src_rt(st[0])),
               src_rt(st[1]) != 5'd0 && dst_of(st[2]) == src_rt(st[1])};
  endtask

  // Drive an instruction after the rising edge, then sit on the falling edge for sampling.
  task automatic drive(input logic [31:0] ins);
    instr_d = ins;
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      st = '{default: '0};
    end else begin
      st[2] = st[1];
      st[1] = st[0];
      st[0] = exp_stall ? 32'h0 : instr_d;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(32'h0);
    advance();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [4:0] rreg();
    int x;
    x = $urandom_range(0, 4);
    return (x == 4) ? 5'd31 : 5'(x);
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [15:0] imm;
    imm = 16'($urandom);
    case ($urandom_range(0, 11))
      0:  return enc_r(rreg(), rreg(), rreg(), 6'h21);
      1:  return enc_r(rreg(), rreg(), rreg(), 6'h23);
      2:  return enc_i(6'h0d, rreg(), rreg(), imm);
      3:  return enc_i(6'h23, rreg(), rreg(), imm);
      4:  return enc_i(6'h2b, rreg(), rreg(), imm);
      5:  return enc_i(6'h04, rreg(), rreg(), imm);
      6:  return enc_i(6'h0f, rreg(), rreg(), imm);
      7:  return {6'h02, 26'($urandom)};
      8:  return {6'h03, 26'($urandom)};
      9:  return enc_r(rreg(), 5'd0, 5'd0, 6'h08);
      10: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    drive(32'h0);
    total++;
    if (all_outs !== 28'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", all_outs);
    end
    advance();
  endtask

  task automatic test_load_use();
    logic [31:0] lw1, addu;
    lw1  = enc_i(6'h23, 5'd0, 5'd1, 16'h0);
    addu = enc_r(5'd1, 5'd3, 5'd2, 6'h21);
    do_reset();
    drive(lw1); advance();
    drive(addu);
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL load_use_stall got=%b want=1", stall); end
    advance();
    drive(addu);
    total++;
    if ({stall, e_alu_src, e_aluc} !== 5'b0) begin
      bad++; $display("FAIL load_use_bubble got=%b want=00000", {stall, e_alu_src, e_aluc});
    end
    advance();
    drive(32'h0);
    total++;
    if (fwd_e_rs !== 2'd2 || e_aluc !== 3'b010) begin
      bad++; $display("FAIL load_use_fwd got=%0d/%b want=2/010", fwd_e_rs, e_aluc);
    end
    advance();
  endtask

  task automatic test_load_branch();
    logic [31:0] beq;
    int n;
    beq = enc_i(6'h04, 5'd1, 5'd0, 16'h4);
    do_reset();
    drive(enc_i(6'h23, 5'd0, 5'd1, 16'h0)); advance();
    n = 0;
    drive(beq);
    while (stall === 1'b1 && n < 5) begin
      n++; advance(); drive(beq);
    end
    total++;
    if (n != 2) begin bad++; $display("FAIL load_branch_stalls got=%0d want=2", n); end
    total++;
    if (fwd_d_rs !== 2'd0 || d_beq !== 1'b1) begin
      bad++; $display("FAIL load_branch_fwd got=%0d/%b want=0/1", fwd_d_rs, d_beq);
    end
    advance();
  endtask

  task automatic test_store_fwd();
    do_reset();
    drive(enc_r(5'd2, 5'd3, 5'd1, 6'h21)); advance();
    drive(enc_i(6'h2b, 5'd2, 5'd1, 16'h0));
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL store_stall got=%b want=0", stall); end
    advance();
    drive(32'h0);
    total++;
    if (fwd_e_rt !== 2'd1) begin bad++; $display("FAIL store_fwd_e got=%0d want=1", fwd_e_rt); end
    advance();
    drive(32'h0);
    total++;
    if (fwd_m_rt !== 1'b1 || m_dm_write !== 1'b1) begin
      bad++; $display("FAIL store_fwd_m got=%b/%b want=1/1", fwd_m_rt, m_dm_write);
    end
    advance();
  endtask

  task automatic test_jal_link();
    do_reset();
    drive({6'h03, 26'h10});
    total++;
    if (d_j !== 1'b1) begin bad++; $display("FAIL jal_dj got=%b want=1", d_j); end
    advance();
    drive(32'h0); advance();
    drive(enc_r(5'd31, 5'd0, 5'd0, 6'h08));
    total++;
    if ({stall, fwd_d_rs, d_jr} !== 4'b0101) begin
      bad++; $display("FAIL jr_fwd got=%b want=0101", {stall, fwd_d_rs, d_jr});
    end
    advance();
    drive(32'h0);
    total++;
    if ({w_grf_we, w_grf_a, w_wsel} !== {1'b1, 5'd31, 2'd2}) begin
      bad++; $display("FAIL jal_wb got=%b/%0d/%0d want=1/31/2", w_grf_we, w_grf_a, w_wsel);
    end
    advance();
  endtask

  task automatic test_reg_zero();
    do_reset();
    drive(enc_i(6'h0d, 5'd0, 5'd0, 16'h5)); advance();
    drive(enc_r(5'd0, 5'd0, 5'd1, 6'h21));
    total++;
    if ({stall, fwd_d_rs, fwd_d_rt} !== 5'b0 || e_zext !== 1'b1 || e_alu_src !== 1'b1) begin
      bad++; $display("FAIL zero_d got=%b zext=%b src=%b want=00000/1/1",
                      {stall, fwd_d_rs, fwd_d_rt}, e_zext, e_alu_src);
    end
    advance();
    drive(32'h0);
    total++;
    if ({fwd_e_rs, fwd_e_rt} !== 4'b0) begin
      bad++; $display("FAIL zero_e got=%b want=0000", {fwd_e_rs, fwd_e_rt});
    end
    advance();
    drive(32'h0);
    total++;
    if (w_grf_we !== 1'b0) begin bad++; $display("FAIL zero_we got=%b want=0", w_grf_we); end
    advance();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(enc_r(5'd2, 5'd3, 5'd1, 6'h21)); advance();
    drive(enc_r(5'd1, 5'd1, 5'd2, 6'h21)); advance();
    drive(enc_r(5'd1, 5'd2, 5'd3, 6'h23));
    total++;
    if ({stall, fwd_e_rs, fwd_e_rt} !== 5'b00101) begin
      bad++; $display("FAIL b2b_first got=%b want=00101", {stall, fwd_e_rs, fwd_e_rt});
    end
    advance();
    drive(32'h0);
    total++;
    if ({fwd_e_rs, fwd_e_rt, e_aluc} !== 7'b1001100) begin
      bad++; $display("FAIL b2b_second got=%b want=1001100", {fwd_e_rs, fwd_e_rt, e_aluc});
    end
    advance();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive(enc_i(6'h23, 5'd2, 5'd1, 16'h8)); advance();
    reset = 1'b1;
    drive(32'hFFFF_FFFF);
    total++;
    if ({e_alu_src, d_beq, d_j, d_jr} !== 4'b1000) begin
      bad++; $display("FAIL midreset_before got=%b want=1000", {e_alu_src, d_beq, d_j, d_jr});
    end
    advance();
    reset = 1'b0;
    drive(32'hFFFF_FFFF);
    total++;
    if (all_outs !== 28'h0) begin
      bad++; $display("FAIL midreset_after got=%h want=0", all_outs);
    end
    advance();
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic        hold;
    do_reset();
    hold = 1'b0;
    ins  = 32'h0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) ins = rand_ins();
      reset = ($urandom_range(0, 63) == 0);
      drive(ins);
      hold = exp_stall && !reset;
      total++;
      if (stall !== exp_stall) begin
        bad++; $display("FAIL rand_stall i=%0d ins=%h got=%b want=%b", i, ins, stall, exp_stall);
      end
      total++;
      if ({d_beq, d_j, d_jr} !== exp_dctl) begin
        bad++; $display("FAIL rand_dctl i=%0d got=%b want=%b", i, {d_beq, d_j, d_jr}, exp_dctl);
      end
      total++;
      if ({e_alu_src, e_aluc, e_zext, e_lui} !== exp_ectl) begin
        bad++; $display("FAIL rand_ectl i=%0d got=%b want=%b", i,
                        {e_alu_src, e_aluc, e_zext, e_lui}, exp_ectl);
      end
      total++;
      if ({m_dm_write, w_grf_we, w_grf_a, w_wsel} !== exp_mw) begin
        bad++; $display("FAIL rand_mw i=%0d got=%b want=%b", i,
                        {m_dm_write, w_grf_we, w_grf_a, w_wsel}, exp_mw);
      end
      total++;
      if ({fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt} !== exp_fwd) begin
        bad++; $display("FAIL rand_fwd i=%0d got=%b want=%b", i,
                        {fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt}, exp_fwd);
      end
      total++;
      if ({nh_stall, nh_fwd_d_rs, nh_fwd_d_rt, nh_fwd_e_rs, nh_fwd_e_rt, nh_fwd_m_rt} !== 10'b0
          || nh_dctl !== exp_dctl) begin
        bad++; $display("FAIL rand_nohaz i=%0d got=%b/%b want=0/%b", i,
                        {nh_stall, nh_fwd_d_rs, nh_fwd_d_rt, nh_fwd_e_rs, nh_fwd_e_rt,
                         nh_fwd_m_rt}, nh_dctl, exp_dctl);
      end
      advance();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    instr_d = 32'h0;
    st      = '{default: '0};
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_load_branch();
    test_store_fwd();
    test_jal_link();
    test_reg_zero();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
